// File: rtl/ula_pkg.sv
// Shared definitions for the ULA control path: opcodes, FSM states and data widths.
package ula_pkg;

  localparam int LARGURA_DADO = 4;
  localparam int LARGURA_RES  = LARGURA_DADO + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  localparam logic [LARGURA_RES-1:0] ERRO_DIV0 = 5'b11111;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EXECUTA = 2'd1,
    ESPERA  = 2'd2,
    ENTREGA = 2'd3
  } estado_t;

  // MUL and DIV are the only operations served by the iterative unit.
  function automatic logic op_iterativa(input logic [2:0] codigo);
    return (codigo == OP_MUL) || (codigo == OP_DIV);
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Cycle counter bounding the wait on the iterative unit; terminal flags TIMEOUT-1.
module contador_timeout #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic habilita,
  input  logic limpa,
  output logic terminal
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] contagem_reg;

  assign terminal = (contagem_reg == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || limpa) begin
      contagem_reg <= '0;
    end else if (habilita && !terminal) begin
      contagem_reg <= contagem_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ula_sequenciador.sv
// Sequencer for the ULA datapath: accepts one request, drives the result mux and
// iterative unit, then delivers the captured result with flags.
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter int LARGURA_DADO = ula_pkg::LARGURA_DADO,
  parameter int LARGURA_RES  = ula_pkg::LARGURA_RES,
  parameter int TIMEOUT      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valido,
  output logic                    req_pronto,
  input  logic [2:0]              op,
  input  logic [LARGURA_DADO-1:0] a,
  input  logic [LARGURA_DADO-1:0] b,
  output logic [LARGURA_DADO-1:0] ula_a,
  output logic [LARGURA_DADO-1:0] ula_b,
  output logic [2:0]              ula_sel,
  output logic                    iter_inicio,
  input  logic                    iter_fim,
  input  logic [LARGURA_RES-1:0]  resultado_ula,
  output logic [LARGURA_RES-1:0]  resultado,
  output logic                    res_valido,
  input  logic                    res_pronto,
  output logic                    flag_zero,
  output logic                    flag_carry,
  output logic                    flag_erro,
  output logic                    ocupado
);

  estado_t estado_reg;
  logic    terminal;

  contador_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .habilita (estado_reg == ESPERA),
    .limpa    (estado_reg == EXECUTA),
    .terminal (terminal)
  );

  // Gating with rst keeps req_pronto low during the reset cycle itself.
  assign req_pronto = (estado_reg == OCIOSO) && !rst;
  assign res_valido = (estado_reg == ENTREGA);
  assign ocupado    = (estado_reg != OCIOSO);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_reg  <= OCIOSO;
      ula_a       <= '0;
      ula_b       <= '0;
      ula_sel     <= '0;
      iter_inicio <= 1'b0;
      resultado   <= '0;
      flag_zero   <= 1'b0;
      flag_carry  <= 1'b0;
      flag_erro   <= 1'b0;
    end else begin
      case (estado_reg)
        OCIOSO: begin
          if (req_valido) begin
            ula_sel   <= op;
            ula_a     <= a;
            ula_b     <= b;
            flag_erro <= 1'b0;
            if (op == OP_DIV && b == '0) begin
              resultado  <= LARGURA_RES'(ERRO_DIV0);
              flag_zero  <= (ERRO_DIV0[LARGURA_DADO-1:0] == '0);
              flag_carry <= ERRO_DIV0[LARGURA_RES-1];
              flag_erro  <= 1'b1;
              estado_reg <= ENTREGA;
            end else begin
              iter_inicio <= op_iterativa(op);
              estado_reg  <= EXECUTA;
            end
          end
        end
        EXECUTA: begin
          iter_inicio <= 1'b0;
          if (op_iterativa(ula_sel)) begin
            estado_reg <= ESPERA;
          end else begin
            resultado  <= resultado_ula;
            flag_zero  <= (resultado_ula[LARGURA_DADO-1:0] == '0);
            flag_carry <= resultado_ula[LARGURA_RES-1];
            estado_reg <= ENTREGA;
          end
        end
        ESPERA: begin
          // A completion seen on the terminal cycle still wins over the timeout.
          if (iter_fim) begin
            resultado  <= resultado_ula;
            flag_zero  <= (resultado_ula[LARGURA_DADO-1:0] == '0);
            flag_carry <= resultado_ula[LARGURA_RES-1];
            estado_reg <= ENTREGA;
          end else if (terminal) begin
            resultado  <= '0;
            flag_zero  <= 1'b1;
            flag_carry <= 1'b0;
            flag_erro  <= 1'b1;
            estado_reg <= ENTREGA;
          end
        end
        ENTREGA: begin
          if (res_pronto) begin
            estado_reg <= OCIOSO;
          end
        end
        default: estado_reg <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with a behavioural result mux model.
module tb_ula_sequenciador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valido = 1'b0;
  logic       req_pronto;
  logic [2:0] op = '0;
  logic [3:0] a = '0, b = '0;
  logic [3:0] ula_a, ula_b;
  logic [2:0] ula_sel;
  logic       iter_inicio;
  logic       iter_fim = 1'b0;
  logic [4:0] resultado_ula;
  logic [4:0] resultado;
  logic       res_valido;
  logic       res_pronto = 1'b0;
  logic       flag_zero, flag_carry, flag_erro, ocupado;
  logic [4:0] iter_val = '0;

  int erros = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ula_sequenciador dut (
    .clk(clk), .rst(rst), .req_valido(req_valido), .req_pronto(req_pronto),
    .op(op), .a(a), .b(b), .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel),
    .iter_inicio(iter_inicio), .iter_fim(iter_fim), .resultado_ula(resultado_ula),
    .resultado(resultado), .res_valido(res_valido), .res_pronto(res_pronto),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_erro(flag_erro),
    .ocupado(ocupado)
  );

  // Result mux model: 5-bit results, carry/borrow in bit 4.
  always_comb begin
    resultado_ula = '0;
    case (ula_sel)
      3'd0: resultado_ula = {1'b0, ula_a} + {1'b0, ula_b};
      3'd1: resultado_ula = {1'b0, ula_a} - {1'b0, ula_b};
      3'd2: resultado_ula = {1'b0, ula_a & ula_b};
      3'd3: resultado_ula = {1'b0, ula_a | ula_b};
      3'd4: resultado_ula = {1'b0, ula_a ^ ula_b};
      3'd5: resultado_ula = {1'b0, ~ula_a};
      default: resultado_ula = iter_val;
    endcase
  end

  task automatic aceitar(input logic [2:0] o, input logic [3:0] va, input logic [3:0] vb);
    req_valido = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    req_valido = 1'b0; op = 3'd3; a = 4'hf; b = 4'hf;
  endtask

  task automatic entregar();
    res_pronto = 1'b1;
    @(negedge clk);
    res_pronto = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_pronto, ocupado, res_valido, iter_inicio} !== 4'b0) begin
      erros++; $display("FAIL reset_ctrl: got %b expected 0000", {req_pronto, ocupado, res_valido, iter_inicio});
    end
    checks++;
    if ({ula_a, ula_b, ula_sel, resultado, flag_zero, flag_carry, flag_erro} !== '0) begin
      erros++; $display("FAIL reset_data: got %h expected 0", {ula_a, ula_b, ula_sel, resultado, flag_zero, flag_carry, flag_erro});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_pronto !== 1'b1) begin
      erros++; $display("FAIL reset_pronto: got %b expected 1", req_pronto);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    aceitar(3'd0, 4'd9, 4'd8);
    checks++;
    if ({ula_sel, ula_a, ula_b, res_valido, ocupado, req_pronto} !== {3'd0, 4'd9, 4'd8, 3'b010}) begin
      erros++; $display("FAIL add_exec: got sel=%0d a=%0d b=%0d v=%b o=%b p=%b expected sel=0 a=9 b=8 v=0 o=1 p=0",
                        ula_sel, ula_a, ula_b, res_valido, ocupado, req_pronto);
    end
    @(negedge clk);
    checks++;
    if ({res_valido, resultado, flag_carry, flag_zero, flag_erro} !== {1'b1, 5'b10001, 3'b100}) begin
      erros++; $display("FAIL add_result: got v=%b r=%b c=%b z=%b e=%b expected v=1 r=10001 c=1 z=0 e=0",
                        res_valido, resultado, flag_carry, flag_zero, flag_erro);
    end
    entregar();
    checks++;
    if ({res_valido, req_pronto, ocupado, ula_sel, ula_a} !== {3'b010, 3'd0, 4'd9}) begin
      erros++; $display("FAIL add_done: got v=%b p=%b o=%b sel=%0d a=%0d expected v=0 p=1 o=0 sel=0 a=9",
                        res_valido, req_pronto, ocupado, ula_sel, ula_a);
    end
  endtask

  task automatic test_sub_hold();
    aceitar(3'd1, 4'd5, 4'd5);
    @(negedge clk);
    checks++;
    if ({res_valido, resultado[3:0], flag_zero, flag_carry} !== {1'b1, 4'd0, 2'b10}) begin
      erros++; $display("FAIL sub_result: got v=%b r=%b z=%b c=%b expected v=1 r=x0000 z=1 c=0",
                        res_valido, resultado, flag_zero, flag_carry);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valido, req_pronto, resultado, flag_zero} !== {2'b10, 5'd0, 1'b1}) begin
        erros++; $display("FAIL sub_hold[%0d]: got v=%b p=%b r=%b z=%b expected v=1 p=0 r=00000 z=1",
                          i, res_valido, req_pronto, resultado, flag_zero);
      end
    end
    entregar();
  endtask

  task automatic test_mul();
    int pulsos = 0;
    iter_val = 5'd12;
    aceitar(3'd6, 4'd3, 4'd4);
    checks++;
    if ({iter_inicio, ocupado, ula_sel} !== {2'b11, 3'd6}) begin
      erros++; $display("FAIL mul_start: got i=%b o=%b sel=%0d expected i=1 o=1 sel=6", iter_inicio, ocupado, ula_sel);
    end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (iter_inicio) pulsos++;
      checks++;
      if ({ocupado, res_valido} !== 2'b10) begin
        erros++; $display("FAIL mul_wait[%0d]: got o=%b v=%b expected o=1 v=0", i, ocupado, res_valido);
      end
    end
    checks++;
    if (pulsos !== 0) begin
      erros++; $display("FAIL mul_pulse: got %0d extra iter_inicio cycles expected 0", pulsos);
    end
    iter_fim = 1'b1;
    @(negedge clk);
    iter_fim = 1'b0;
    checks++;
    if ({res_valido, resultado, flag_zero, flag_carry, flag_erro} !== {1'b1, 5'd12, 3'b000}) begin
      erros++; $display("FAIL mul_result: got v=%b r=%0d z=%b c=%b e=%b expected v=1 r=12 z=0 c=0 e=0",
                        res_valido, resultado, flag_zero, flag_carry, flag_erro);
    end
    entregar();
  endtask

  task automatic test_div0();
    aceitar(3'd7, 4'd9, 4'd0);
    checks++;
    if ({res_valido, iter_inicio, resultado, flag_erro, flag_carry, flag_zero} !== {2'b10, 5'b11111, 3'b110}) begin
      erros++; $display("FAIL div0: got v=%b i=%b r=%b e=%b c=%b z=%b expected v=1 i=0 r=11111 e=1 c=1 z=0",
                        res_valido, iter_inicio, resultado, flag_erro, flag_carry, flag_zero);
    end
    entregar();
  endtask

  task automatic test_timeout();
    int n = 0;
    iter_val = 5'd7;
    aceitar(3'd7, 4'd9, 4'd2);
    checks++;
    if ({iter_inicio, flag_erro} !== 2'b10) begin
      erros++; $display("FAIL div_start: got i=%b e=%b expected i=1 e=0", iter_inicio, flag_erro);
    end
    while (!res_valido && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 33) begin
      erros++; $display("FAIL div_timeout_cycles: got %0d expected 33", n);
    end
    checks++;
    if ({res_valido, resultado, flag_erro, flag_zero, flag_carry} !== {1'b1, 5'd0, 3'b110}) begin
      erros++; $display("FAIL div_timeout: got v=%b r=%b e=%b z=%b c=%b expected v=1 r=00000 e=1 z=1 c=0",
                        res_valido, resultado, flag_erro, flag_zero, flag_carry);
    end
    entregar();
  endtask

  task automatic test_rst_mid();
    aceitar(3'd6, 4'd3, 4'd4);
    repeat (4) @(negedge clk);
    checks++;
    if ({ocupado, res_valido} !== 2'b10) begin
      erros++; $display("FAIL mid_espera: got o=%b v=%b expected o=1 v=0", ocupado, res_valido);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_pronto, ocupado, res_valido, iter_inicio, ula_a, ula_b, ula_sel, resultado,
         flag_zero, flag_carry, flag_erro} !== '0) begin
      erros++; $display("FAIL mid_reset: got p=%b o=%b v=%b i=%b a=%0d b=%0d sel=%0d r=%0d flags=%b expected all 0",
                        req_pronto, ocupado, res_valido, iter_inicio, ula_a, ula_b, ula_sel, resultado,
                        {flag_zero, flag_carry, flag_erro});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_pronto, ocupado} !== 2'b10) begin
      erros++; $display("FAIL mid_after: got p=%b o=%b expected p=1 o=0", req_pronto, ocupado);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_hold();
    test_mul();
    test_div0();
    test_timeout();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule

// File: doc/ula_sequenciador.md
# ula_sequenciador

Control block for the ULA datapath. It accepts one operation request at a time through a valid/ready handshake and registers the operands. It then drives the 3-bit select of the 5-bit 8:1 result multiplexer and starts and waits on the iterative multiply and divide units. Finally it captures the multiplexer output into a result register with flags and presents it through a second valid/ready handshake. It sits between the operand/opcode source (switch or command front end) and the ULA result mux.

## Interface
- LARGURA_DADO, 4, operand width
- LARGURA_RES, 5, result width (LARGURA_DADO+1, carry in MSB)
- TIMEOUT, 32, max cycles to wait for iterative unit completion
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valido  in  1  request present
- req_pronto  out  1  controller can accept a request
- op  in  3  opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 MUL, 7 DIV)
- a, b  in  LARGURA_DADO  operands
- ula_a, ula_b  out  LARGURA_DADO  registered operands to datapath
- ula_sel  out  3  select to result mux
- iter_inicio  out  1  one-cycle start pulse to MUL/DIV unit
- iter_fim  in  1  MUL/DIV unit done (level, sampled only in ESPERA)
- resultado_ula  in  LARGURA_RES  result mux output
- resultado  out  LARGURA_RES  captured result
- res_valido  out  1  result available
- res_pronto  in  1  consumer accepts result
- flag_zero, flag_carry, flag_erro  out  1 each  status of captured result
- ocupado  out  1  high in any state except OCIOSO

## Operation
- States: OCIOSO, EXECUTA, ESPERA, ENTREGA.
- OCIOSO:
  - req_pronto=1.
  - On req_valido&req_pronto: register op→ula_sel, a→ula_a, b→ula_b, and go to EXECUTA.
  - Exception: op=7 with b=0 skips the datapath, loads resultado=5'b11111 and flag_erro=1, and goes directly to ENTREGA.
- EXECUTA, op 0–5: capture resultado_ula at the end of the cycle and go to ENTREGA.
- EXECUTA, op 6–7: assert iter_inicio for exactly this cycle, clear the timeout counter, and go to ESPERA.
- ESPERA:
  - Counter increments each cycle.
  - iter_fim=1: capture resultado_ula and go to ENTREGA.
  - Counter reaches TIMEOUT-1 without iter_fim: resultado=0, flag_erro=1, go to ENTREGA.
  - If iter_fim and timeout occur in the same cycle, iter_fim wins.
- ENTREGA:
  - res_valido=1, and resultado and flags are held stable.
  - On res_pronto go to OCIOSO.
- Flags, computed from the captured value:
  - flag_zero = (resultado[LARGURA_DADO-1:0]==0).
  - flag_carry = resultado[LARGURA_RES-1].
  - flag_erro only as above; it is cleared on each new accept.
- ula_sel, ula_a and ula_b stay unchanged from accept until the next accept.
- Inputs a, b and op are ignored outside the accept cycle.

## Timing
- Reset values:
  - req_pronto=0 during the rst cycle, 1 from the first cycle after it.
  - State OCIOSO.
  - All other outputs 0: ula_a, ula_b, ula_sel, iter_inicio, resultado, res_valido, flags, ocupado.
- Single-cycle ops: accept at edge T, capture at edge T+1, res_valido high from T+1 to the edge where res_pronto is sampled high. Minimum 3 cycles per transaction (accept, execute, deliver).
- Multi-cycle ops: iter_inicio high for the cycle following accept. Result captured on the edge where iter_fim is sampled high.
- Divide-by-zero: res_valido high one cycle after accept.
- No back-to-back accept: req_pronto is low from the accept edge until the cycle after the ENTREGA handshake.
- rst mid-operation: returns to OCIOSO next edge, drops iter_inicio/res_valido, discards pending result.

## Structure
- Package ula_pkg:
  - opcode constants (OP_ADD … OP_DIV)
  - state encoding
  - LARGURA_DADO/LARGURA_RES defaults
  - ERRO_DIV0 value 5'b11111
- Sub-module contador_timeout: enable, clear, terminal-count output at TIMEOUT-1.
- FSM and registers in ula_sequenciador.

## Test plan
- Reset, then op=0, a=4'd9, b=4'd8 with a model mux → ula_sel=0, resultado=5'b10001, flag_carry=1, flag_zero=0, res_valido at accept+1.
- op=1 (SUB), a=5, b=5 → resultado low nibble 0, flag_zero=1. Hold res_pronto=0 for 4 cycles → res_valido and resultado stable, req_pronto=0 throughout.
- op=6, a=3, b=4, iter_fim asserted 6 cycles after iter_inicio with resultado_ula=12 → single-cycle iter_inicio pulse, resultado=12, ocupado high through ESPERA.
- op=7, b=0 → no iter_inicio, resultado=5'b11111, flag_erro=1, res_valido one cycle after accept.
- op=7, iter_fim never asserted → after TIMEOUT cycles resultado=0, flag_erro=1. Then assert rst during a fresh MUL in ESPERA → all outputs 0, req_pronto=1 after reset.
